dma_module: RTL and testbench
=============================

# dma_module

Object-attribute-memory DMA engine for the CPU memory-mapped bus. It responds to CPU writes of a source page number on register FF46. It then becomes a bus initiator, copying 160 bytes from {page, 8'h00}..{page, 8'h9F} to FE00..FE9F as alternating read and write cycles. It sits beside the timer and other FFxx I/O responders on the CPU bus, and its master port feeds the system bus arbiter.

## Interface
Parameters:
- REG_ADDR, 16'hFF46, CPU address of the DMA source/trigger register
- DEST_BASE, 16'hFE00, first destination address
- LENGTH, 160, bytes per transfer (8-bit counter; must be 1..256)

Ports:
- I_CLOCK  input  1  system clock; all state changes on rising edge
- I_RESET_L  input  1  reset; one clock, synchronous, active-low
- I_ADDR  input  16  CPU bus address
- IO_DATA  inout  8  CPU bus data; driven only during a register read
- I_RE_L  input  1  CPU read strobe, active-low
- I_WE_L  input  1  CPU write strobe, active-low
- O_MASTER_ADDR  output  16  DMA initiator address
- I_MASTER_DATA  input  8  read data returned by the addressed responder during a DMA read cycle
- O_MASTER_DATA  output  8  DMA write data
- O_MASTER_RE_L  output  1  DMA read strobe, active-low
- O_MASTER_WE_L  output  1  DMA write strobe, active-low
- O_DMA_ACTIVE  output  1  high while the engine owns the bus (arbiter stalls the CPU)
- O_DMA_DONE  output  1  one-cycle pulse after the final write

## Operation
- Register write: on a rising edge with I_WE_L=0 and I_ADDR==REG_ADDR:
  - IO_DATA is latched into the page register.
  - The byte index is cleared to 0.
  - The state goes to START.
- Register read: while I_RE_L=0 and I_ADDR==REG_ADDR, IO_DATA is driven with the page register (combinational). In all other cases IO_DATA is 8'hZZ.
- The register stays readable and writable while a transfer is active.
- States: IDLE, START, READ, WRITE.
  - IDLE: master strobes high; ACTIVE=0.
  - START: one cycle; ACTIVE=1; strobes high. Next state is READ.
  - READ: O_MASTER_ADDR={page, idx}; O_MASTER_RE_L=0. At the rising edge, I_MASTER_DATA is latched into the data buffer. Next state is WRITE.
  - WRITE: O_MASTER_ADDR=DEST_BASE+idx; O_MASTER_DATA=buffer; O_MASTER_WE_L=0. At the rising edge, if idx==LENGTH-1 the next state is IDLE and DONE is pulsed; otherwise idx increments and the next state is READ.
- Address arithmetic is 16 bits. The low byte is idx (8 bits), and the destination add wraps modulo 2^16.
- Master outputs are decoded only from registered state, idx and buffer, with no combinational path from CPU inputs.
  - O_MASTER_ADDR and O_MASTER_DATA hold their last value in IDLE and START.
  - O_MASTER_DATA is don't-care unless WE_L=0.

## Timing
- Reset values:
  - state IDLE; page 8'h00; idx 0; buffer 8'h00
  - O_MASTER_ADDR 16'h0000; O_MASTER_DATA 8'h00
  - RE_L/WE_L 1; O_DMA_ACTIVE 0; O_DMA_DONE 0; IO_DATA Z
- Latency: register write sampled at edge W, so START occupies cycle W+1 and the first READ occupies W+2.
- The last WRITE is in cycle W+1+2*LENGTH, and the DONE pulse is in the following cycle.
- With LENGTH=160, ACTIVE is high for exactly 321 cycles.
- Exactly one strobe is low in READ/WRITE; never both.
- Write during an active transfer (simultaneous with any state): the new page is latched, idx=0, and the state goes to START. The in-flight cycle completes only as a strobe in that one cycle; no DONE is produced for the aborted transfer.
- I_WE_L held low across N edges at REG_ADDR counts as N writes: each edge restarts.
- Reset asserted mid-transfer: at that edge all state returns to reset values, no further strobes are issued and no DONE pulse occurs. Reset has priority over a simultaneous register write.
- A write with I_RE_L=0 simultaneously: the write takes effect, and the read shows the old value until the edge.

## Test plan
- Reset, then CPU write 8'hC1 to FF46 at edge W:
  - ACTIVE rises at W+1.
  - Cycle W+2 shows RE_L=0 with addr C100.
  - Cycle W+3 shows WE_L=0 with addr FE00 and the data from a memory model.
  - 160 pairs end at FE9F; DONE pulses at W+322; ACTIVE is low at W+322.
- Memory model preloaded with C100+i = i^8'h5A: the destination FE00..FE9F holds identical bytes, and no access falls outside C100..C19F / FE00..FE9F.
- CPU read of FF46 after writing 8'hC1 returns 8'hC1. A read of FF07 leaves IO_DATA at Z, and a read of FF46 during transfer still returns 8'hC1.
- Rewrite FF46 with 8'h80 at byte index 50: the next READ after START is at 8000, the transfer completes 160 fresh bytes, and only one DONE pulse occurs.
- I_RESET_L low at byte index 100:
  - Next cycle: ACTIVE=0, both strobes 1, addr 0000, no DONE.
  - A later write of 8'hC1 runs a full clean transfer.
- Page 8'hFF: reads span FF00..FF9F with no address carry into the page byte. Reads and writes never overlap in the same cycle across the whole run.

Source files
------------

// File: rtl/dma_module.sv
// dma_module: OAM-style DMA engine. A CPU write of a source page to REG_ADDR
// starts a copy of LENGTH bytes from {page, 8'h00} to DEST_BASE, issued as
// alternating master read and write cycles on the system bus.
module dma_module #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] DEST_BASE = 16'hFE00,
    parameter int unsigned LENGTH    = 160
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET_L,
    input  logic [15:0] I_ADDR,
    inout  wire  [7:0]  IO_DATA,
    input  logic        I_RE_L,
    input  logic        I_WE_L,
    output logic [15:0] O_MASTER_ADDR,
    input  logic [7:0]  I_MASTER_DATA,
    output logic [7:0]  O_MASTER_DATA,
    output logic        O_MASTER_RE_L,
    output logic        O_MASTER_WE_L,
    output logic        O_DMA_ACTIVE,
    output logic        O_DMA_DONE
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] buffer;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] idx_next;

    assign reg_write = !I_WE_L && (I_ADDR == REG_ADDR);
    assign reg_read  = !I_RE_L && (I_ADDR == REG_ADDR);
    assign idx_next  = 8'(idx + 8'd1);

    // Register read-back: page value driven only during a CPU read of REG_ADDR
    assign IO_DATA = reg_read ? page : 8'hzz;

    // Transfer sequencer; master outputs are registered alongside the state
    // so that each cycle's strobe/address reflects the state it belongs to.
    always_ff @(posedge I_CLOCK) begin
        if (!I_RESET_L) begin
            state         <= IDLE;
            page          <= 8'h00;
            idx           <= 8'h00;
            buffer        <= 8'h00;
            O_MASTER_ADDR <= 16'h0000;
            O_MASTER_DATA <= 8'h00;
            O_MASTER_RE_L <= 1'b1;
            O_MASTER_WE_L <= 1'b1;
            O_DMA_ACTIVE  <= 1'b0;
            O_DMA_DONE    <= 1'b0;
        end else begin
            O_DMA_DONE <= 1'b0;
            if (reg_write) begin
                // A register write (re)starts the transfer from any state
                page          <= IO_DATA;
                idx           <= 8'h00;
                state         <= START;
                O_MASTER_RE_L <= 1'b1;
                O_MASTER_WE_L <= 1'b1;
                O_DMA_ACTIVE  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        O_MASTER_RE_L <= 1'b1;
                        O_MASTER_WE_L <= 1'b1;
                        O_DMA_ACTIVE  <= 1'b0;
                    end
                    START: begin
                        state         <= READ;
                        O_MASTER_ADDR <= {page, idx};
                        O_MASTER_RE_L <= 1'b0;
                        O_MASTER_WE_L <= 1'b1;
                    end
                    READ: begin
                        state         <= WRITE;
                        buffer        <= I_MASTER_DATA;
                        O_MASTER_ADDR <= 16'(DEST_BASE + 16'(idx));
                        O_MASTER_DATA <= I_MASTER_DATA;
                        O_MASTER_RE_L <= 1'b1;
                        O_MASTER_WE_L <= 1'b0;
                    end
                    WRITE: begin
                        O_MASTER_WE_L <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state        <= IDLE;
                            O_DMA_ACTIVE <= 1'b0;
                            O_DMA_DONE   <= 1'b1;
                        end else begin
                            state         <= READ;
                            idx           <= idx_next;
                            O_MASTER_ADDR <= {page, idx_next};
                            O_MASTER_RE_L <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_module.sv
// tb_dma_module: directed stimulus with a cycle-offset reference model and
// a per-cycle compare of all master outputs.
module tb_dma_module;

    localparam int unsigned LEN = 160;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_re_l;
    logic        cpu_we_l;
    logic        cpu_oe;
    logic [7:0]  cpu_dout;
    wire  [7:0]  io_data;
    logic [15:0] m_addr;
    logic [7:0]  m_rdata;
    logic [7:0]  m_wdata;
    logic        m_re_l;
    logic        m_we_l;
    logic        active;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign io_data = cpu_oe ? cpu_dout : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (io_data[g]);
    end

    // Source memory contents: page C1 holds i^5A, other pages a distinct pattern
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h33;
    endfunction

    assign m_rdata = mem_byte(m_addr);

    dma_module dut (
        .I_CLOCK       (clk),
        .I_RESET_L     (rst_n),
        .I_ADDR        (cpu_addr),
        .IO_DATA       (io_data),
        .I_RE_L        (cpu_re_l),
        .I_WE_L        (cpu_we_l),
        .O_MASTER_ADDR (m_addr),
        .I_MASTER_DATA (m_rdata),
        .O_MASTER_DATA (m_wdata),
        .O_MASTER_RE_L (m_re_l),
        .O_MASTER_WE_L (m_we_l),
        .O_DMA_ACTIVE  (active),
        .O_DMA_DONE    (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: 'since' is the number of edges since the triggering
    // write edge, so cycle W+since. Outputs follow from that offset alone.
    int          since = -1;
    int          off_m;
    int          j_m;
    logic [7:0]  page_m = 8'h00;
    logic        exp_active = 1'b0;
    logic        exp_re_l = 1'b1;
    logic        exp_we_l = 1'b1;
    logic        exp_done = 1'b0;
    logic [15:0] exp_addr = 16'h0000;
    logic [7:0]  exp_data = 8'h00;
    logic        chk_on = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            since    = -1;
            page_m   = 8'h00;
            exp_addr = 16'h0000;
        end else if (!cpu_we_l && cpu_addr == 16'hFF46) begin
            since  = 1;
            page_m = io_data;
        end else if (since >= 0) begin
            since++;
            if (since > int'(2 * LEN + 2)) since = -1;
        end
        exp_active = (since >= 1) && (since <= int'(2 * LEN + 1));
        exp_re_l   = 1'b1;
        exp_we_l   = 1'b1;
        exp_done   = (since == int'(2 * LEN + 2));
        if (since >= 2 && since <= int'(2 * LEN + 1)) begin
            off_m = since - 2;
            j_m   = off_m / 2;
            if (off_m % 2 == 0) begin
                exp_re_l = 1'b0;
                exp_addr = {page_m, 8'(j_m)};
            end else begin
                exp_we_l = 1'b0;
                exp_addr = 16'(16'hFE00 + 16'(j_m));
                exp_data = mem_byte({page_m, 8'(j_m)});
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("active", 32'(active), 32'(exp_active));
            chk("re_l", 32'(m_re_l), 32'(exp_re_l));
            chk("we_l", 32'(m_we_l), 32'(exp_we_l));
            chk("done", 32'(done), 32'(exp_done));
            chk("addr", 32'(m_addr), 32'(exp_addr));
            chk("strobe_overlap", 32'(m_re_l | m_we_l), 32'd1);
            if (!exp_we_l) chk("wdata", 32'(m_wdata), 32'(exp_data));
        end
    end

    // Destination capture and out-of-window access tally
    logic [7:0] dst [0:LEN-1];
    int         oob = 0;

    always @(posedge clk) begin
        if (rst_n && !m_we_l) begin
            if (m_addr >= 16'hFE00 && m_addr < 16'(16'hFE00 + 16'(LEN)))
                dst[m_addr - 16'hFE00] <= m_wdata;
            else
                oob <= oob + 1;
        end
        if (rst_n && !m_re_l && (m_addr[7:0] >= 8'(LEN)))
            oob <= oob + 1;
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        cpu_oe   = 1'b1;
        cpu_we_l = 1'b0;
        @(negedge clk);
        cpu_we_l = 1'b1;
        cpu_oe   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_re_l = 1'b0;
        #1;
        d        = io_data;
        cpu_re_l = 1'b1;
        cpu_addr = 16'h0000;
    endtask

    task automatic run(input int n, output int dn);
        dn = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) dn++;
        end
    endtask

    logic [7:0] rd;
    int         act_n;
    int         done_n;
    int         done_at;

    initial begin
        rst_n    = 1'b0;
        cpu_addr = 16'h0000;
        cpu_re_l = 1'b1;
        cpu_we_l = 1'b1;
        cpu_oe   = 1'b0;
        cpu_dout = 8'h00;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Reset state
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_re_l", 32'(m_re_l), 32'd1);
        chk("rst_we_l", 32'(m_we_l), 32'd1);
        chk("rst_addr", 32'(m_addr), 32'h0000);
        chk("rst_wdata", 32'(m_wdata), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        cpu_read(16'hFF46, rd);
        chk("rst_page_read", 32'(rd), 32'h00);

        // Full transfer from page C1
        cpu_write(16'hFF46, 8'hC1);
        act_n = 0; done_n = 0; done_at = 0;
        for (int cyc = 1; cyc <= 330; cyc++) begin
            if (active) act_n++;
            if (done) begin done_n++; done_at = cyc; end
            if (cyc == 1) chk("w1_active", 32'(active), 32'd1);
            if (cyc == 2) begin
                chk("w2_re_l", 32'(m_re_l), 32'd0);
                chk("w2_addr", 32'(m_addr), 32'hC100);
            end
            if (cyc == 3) begin
                chk("w3_we_l", 32'(m_we_l), 32'd0);
                chk("w3_addr", 32'(m_addr), 32'hFE00);
                chk("w3_data", 32'(m_wdata), 32'h5A);
            end
            if (cyc == 321) chk("w321_addr", 32'(m_addr), 32'hFE9F);
            if (cyc == 10) begin
                cpu_read(16'hFF07, rd);
                chk("rd_ff07_undriven", 32'(rd), 32'hFF);
            end
            if (cyc == 20) begin
                cpu_read(16'hFF46, rd);
                chk("rd_ff46_busy", 32'(rd), 32'hC1);
            end
            @(negedge clk);
        end
        chk("active_cycles", 32'(act_n), 32'd321);
        chk("done_count", 32'(done_n), 32'd1);
        chk("done_cycle", 32'(done_at), 32'd322);
        for (int i = 0; i < int'(LEN); i++)
            chk("dst_byte", 32'(dst[i]), 32'(8'(i) ^ 8'h5A));
        chk("oob_access", 32'(oob), 32'd0);
        cpu_read(16'hFF46, rd);
        chk("rd_ff46_idle", 32'(rd), 32'hC1);

        // Rewrite with page 80 while byte 50 is being read
        cpu_write(16'hFF46, 8'hC1);
        run(101, done_n);
        chk("pre_rewrite_addr", 32'(m_addr), 32'hC132);
        cpu_write(16'hFF46, 8'h80);
        chk("rewrite_start_active", 32'(active), 32'd1);
        chk("rewrite_start_re_l", 32'(m_re_l), 32'd1);
        @(negedge clk);
        chk("rewrite_read_addr", 32'(m_addr), 32'h8000);
        chk("rewrite_read_re_l", 32'(m_re_l), 32'd0);
        run(400, done_n);
        chk("rewrite_done_count", 32'(done_n), 32'd1);

        // Reset in the middle of a transfer at byte 100
        cpu_write(16'hFF46, 8'hC1);
        run(201, done_n);
        chk("pre_reset_addr", 32'(m_addr), 32'hC164);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_re_l", 32'(m_re_l), 32'd1);
        chk("mid_rst_we_l", 32'(m_we_l), 32'd1);
        chk("mid_rst_addr", 32'(m_addr), 32'h0000);
        chk("mid_rst_done", 32'(done), 32'd0);
        run(50, done_n);
        chk("post_rst_no_done", 32'(done_n), 32'd0);
        cpu_write(16'hFF46, 8'hC1);
        run(330, done_n);
        chk("post_rst_done_count", 32'(done_n), 32'd1);

        // Page FF: no carry into the page byte
        cpu_write(16'hFF46, 8'hFF);
        @(negedge clk);
        chk("ff_first_addr", 32'(m_addr), 32'hFF00);
        run(318, done_n);
        chk("ff_last_read_addr", 32'(m_addr), 32'hFF9F);
        chk("ff_last_read_re_l", 32'(m_re_l), 32'd0);
        run(10, done_n);
        chk("ff_done_count", 32'(done_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
